psram_port_arbiter: RTL and testbench
=====================================

// Module: psram_port_arbiter
// PURPOSE
//  Shares the single 8-bit PSRAM memory controller between two requesters: port 0 (video fetch) and port 1 (CPU).
//  Sits between the requesters and the controller's cs/write/address/data/busy/dataReady interface.
//  Grants one request at a time and generates the controller's active-low, edge-triggered cs.
//  Returns read data plus a one-cycle acknowledge to the granted port.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in ISSUE without i_mem_busy rising before the transaction is aborted
// PORTS
//  i_clkRAM         in   1   RAM clock (100 MHz)
//  reset            in   1   asynchronous, active-low reset
//  i_req0/i_req1    in   1   request, held high until matching ack
//  i_we0/i_we1      in   1   1=write, 0=read; stable while req high
//  i_addr0/i_addr1  in   24  byte address; stable while req high
//  i_wdata0/i_wdata1 in  8   write data; stable while req high
//  o_rdata0/o_rdata1 out 8   read data; valid at ack, held until next read ack on that port
//  o_ack0/o_ack1    out  1   one-cycle completion pulse
//  o_mem_cs         out  1   controller chip select, 0=start transaction
//  o_mem_write      out  1   controller direction, 1=write
//  o_mem_address    out  24  controller address
//  o_mem_wdata      out  8   controller write data
//  i_mem_rdata      in   8   controller read data
//  i_mem_busy       in   1   controller busy (1 during init and transfers)
//  i_mem_dataReady  in   1   controller read-complete flag
//  o_timeout        out  1   sticky abort flag; cleared only by reset
// BEHAVIOUR
//  Reset values: o_mem_cs=1; o_ack*=0; o_rdata*=8'h00; o_mem_write=0; o_mem_address=0; o_mem_wdata=0; o_timeout=0; state=IDLE; rr_last=1.
//  Reset mid-transaction aborts it silently: no ack is issued.
//  The controller shares the same reset.
//  States: IDLE, ISSUE, WAIT.
//  IDLE:
//   - If (i_req0|i_req1) and !i_mem_busy: pick the winner and latch its we/addr/wdata onto the o_mem_* outputs.
//   - Drive o_mem_cs<=0 and go to ISSUE.
//   - With no request, or while i_mem_busy=1 (e.g. during controller init), stay in IDLE with cs=1.
//  ISSUE:
//   - Hold o_mem_cs=0 and count.
//   - On i_mem_busy=1: o_mem_cs<=1, clear the counter, go to WAIT.
//   - When the count reaches TIMEOUT_CYCLES: o_mem_cs<=1, o_timeout<=1, pulse the winner's ack with o_rdata unchanged, go to IDLE.
//  WAIT:
//   - On i_mem_busy=0, if the transaction is a read: o_rdataN<=i_mem_rdata (i_mem_dataReady must be 1; it is checked by an assertion).
//   - On the same edge: o_ackN<=1 for one cycle, go to IDLE.
//  cs returns high for at least one cycle between transactions, as the controller requires.
//  Latency: grant edge -> cs low; ack follows busy falling by one edge.
//  A request still held in the cycle after its ack counts as a new request.
//  A requester must drop req on the ack cycle to avoid a repeat access.
//  Only one transaction is outstanding at a time; o_ack0 and o_ack1 are never high together.
//  Address and data are latched at grant, so requester changes after the grant have no effect.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN undefined:
//   - Fixed priority: port 0 wins whenever both ports request.
//   - Port 1 can starve under continuous port-0 traffic.
//  ARB_ROUND_ROBIN_EN defined:
//   - When both ports request, grant the port != rr_last.
//   - rr_last updates on every grant.
//   - A lone requester is always granted.
// STRUCTURE
//  Package psram_arb_pkg holds:
//   - typedef enum arb_state_t {IDLE, ISSUE, WAIT};
//   - localparam PORT_VIDEO=0, PORT_CPU=1.
//  Sub-module psram_arb_pick is purely combinational:
//   - inputs: req[1:0], rr_last;
//   - outputs: grant_valid, grant_idx;
//   - contains the ARB_ROUND_ROBIN_EN selection.
// TESTING (bench models controller: busy rises 1 cycle after cs low, read returns after 20 cycles)
//  - Reset with i_mem_busy=1 for 100 cycles plus a pending req1 -> no cs pulse until busy falls; then exactly one cs-low run.
//  - Port 1 write addr 24'h000400 data 8'hA5 -> o_mem_write=1, address/data match; o_ack1 pulses once; o_ack0 stays 0.
//  - Port 0 read addr 24'h00D000, model returns 8'h3C -> o_rdata0=8'h3C at o_ack0; o_rdata1 unchanged.
//  - req0 and req1 rise on the same cycle, held for 4 transactions:
//     - fixed priority: grant order 0,0,0,0;
//     - with ARB_ROUND_ROBIN_EN: 0,1,0,1.
//  - Model never raises busy -> after 64 ISSUE cycles: cs high, o_timeout=1, requester acked; the next request is still served.
//  - Reset asserted in WAIT -> all outputs return to reset values within the reset cycle; no ack is seen after release.

Source files
------------

// File: rtl/psram_arb_pkg.sv
// Shared types and port indices for the PSRAM port arbiter.
package psram_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

   localparam logic PORT_VIDEO = 1'b0;
   localparam logic PORT_CPU   = 1'b1;

endpackage

// File: rtl/psram_arb_pick.sv
// Combinational winner selection for the two PSRAM requesters.
// Fixed priority (port 0 first) by default; round robin when ARB_ROUND_ROBIN_EN is defined.
module psram_arb_pick
   import psram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_last,
   output logic       grant_valid,
   output logic       grant_idx
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      grant_valid = |req;
      grant_idx   = PORT_VIDEO;
      if (req == 2'b11)
         grant_idx = ~rr_last;
      else if (req[1])
         grant_idx = PORT_CPU;
   end
`else
   logic unused_rr_last;
   assign unused_rr_last = rr_last;

   always_comb begin
      grant_valid = |req;
      grant_idx   = (req[1] && !req[0]) ? PORT_CPU : PORT_VIDEO;
   end
`endif

endmodule

// File: rtl/psram_port_arbiter.sv
// Two-port arbiter in front of the 8-bit PSRAM controller: grants one request at a time,
// drives the edge-triggered cs, returns read data and a one-cycle ack. Selection policy via ARB_ROUND_ROBIN_EN.
module psram_port_arbiter
   import psram_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        i_clkRAM,
   input  logic        reset,
   input  logic        i_req0,
   input  logic        i_req1,
   input  logic        i_we0,
   input  logic        i_we1,
   input  logic [23:0] i_addr0,
   input  logic [23:0] i_addr1,
   input  logic [7:0]  i_wdata0,
   input  logic [7:0]  i_wdata1,
   output logic [7:0]  o_rdata0,
   output logic [7:0]  o_rdata1,
   output logic        o_ack0,
   output logic        o_ack1,
   output logic        o_mem_cs,
   output logic        o_mem_write,
   output logic [23:0] o_mem_address,
   output logic [7:0]  o_mem_wdata,
   input  logic [7:0]  i_mem_rdata,
   input  logic        i_mem_busy,
   input  logic        i_mem_dataReady,
   output logic        o_timeout
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   arb_state_t    state_q, state_d;
   logic          cs_q, cs_d;
   logic          we_q, we_d;
   logic [23:0]   addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    rdata0_q, rdata0_d;
   logic [7:0]    rdata1_q, rdata1_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic          timeout_q, timeout_d;
   logic          rr_last_q, rr_last_d;
   logic          win_q, win_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic grant_valid, grant_idx;

   psram_arb_pick u_pick (
      .req         ({i_req1, i_req0}),
      .rr_last     (rr_last_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_d   = state_q;
      cs_d      = cs_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      timeout_d = timeout_q;
      rr_last_d = rr_last_q;
      win_d     = win_q;
      cnt_d     = cnt_q;
      case (state_q)
         // No grant in the ack cycle: the acked requester is still dropping req.
         IDLE: if (grant_valid && !i_mem_busy && !(ack0_q || ack1_q)) begin
            win_d     = grant_idx;
            rr_last_d = grant_idx;
            we_d      = (grant_idx == PORT_CPU) ? i_we1    : i_we0;
            addr_d    = (grant_idx == PORT_CPU) ? i_addr1  : i_addr0;
            wdata_d   = (grant_idx == PORT_CPU) ? i_wdata1 : i_wdata0;
            cs_d      = 1'b0;
            cnt_d     = '0;
            state_d   = ISSUE;
         end
         ISSUE: if (i_mem_busy) begin
            cs_d    = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end else if (cnt_q == CNT_LAST) begin
            cs_d      = 1'b1;
            timeout_d = 1'b1;
            ack0_d    = (win_q == PORT_VIDEO);
            ack1_d    = (win_q == PORT_CPU);
            state_d   = IDLE;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         WAIT: if (!i_mem_busy) begin
            if (!we_q) begin
               if (win_q == PORT_CPU) rdata1_d = i_mem_rdata;
               else                   rdata0_d = i_mem_rdata;
            end
            ack0_d  = (win_q == PORT_VIDEO);
            ack1_d  = (win_q == PORT_CPU);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clkRAM or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cs_q      <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         timeout_q <= 1'b0;
         rr_last_q <= 1'b1;
         win_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         cs_q      <= cs_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         timeout_q <= timeout_d;
         rr_last_q <= rr_last_d;
         win_q     <= win_d;
         cnt_q     <= cnt_d;
      end
   end

   rd_ready_chk: assert property (@(posedge i_clkRAM) disable iff (!reset)
      (state_q == WAIT && !i_mem_busy && !we_q) |-> i_mem_dataReady);

   assign o_mem_cs      = cs_q;
   assign o_mem_write   = we_q;
   assign o_mem_address = addr_q;
   assign o_mem_wdata   = wdata_q;
   assign o_rdata0      = rdata0_q;
   assign o_rdata1      = rdata1_q;
   assign o_ack0        = ack0_q;
   assign o_ack1        = ack1_q;
   assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench for psram_port_arbiter with a simple PSRAM controller model
// (busy rises one cycle after cs low, completes 20 cycles later).
module tb_psram_port_arbiter;

   logic        clk, rst_n;
   logic        req0, req1, we0, we1;
   logic [23:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic [7:0]  rdata0, rdata1;
   logic        ack0, ack1;
   logic        mem_cs, mem_write;
   logic [23:0] mem_address;
   logic [7:0]  mem_wdata;
   logic        mem_busy, timeout;

   int vectors = 0;
   int errors  = 0;
   bit both_seen = 0;

   logic       init_busy, mute;
   logic       m_busy, m_active, m_dr;
   int         m_cnt;
   logic [7:0] m_rdata, m_resp;

   psram_port_arbiter dut (
      .i_clkRAM        (clk),
      .reset           (rst_n),
      .i_req0          (req0),
      .i_req1          (req1),
      .i_we0           (we0),
      .i_we1           (we1),
      .i_addr0         (addr0),
      .i_addr1         (addr1),
      .i_wdata0        (wdata0),
      .i_wdata1        (wdata1),
      .o_rdata0        (rdata0),
      .o_rdata1        (rdata1),
      .o_ack0          (ack0),
      .o_ack1          (ack1),
      .o_mem_cs        (mem_cs),
      .o_mem_write     (mem_write),
      .o_mem_address   (mem_address),
      .o_mem_wdata     (mem_wdata),
      .i_mem_rdata     (m_rdata),
      .i_mem_busy      (mem_busy),
      .i_mem_dataReady (m_dr),
      .o_timeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_active <= 1'b0; m_dr <= 1'b0; m_cnt <= 0; m_rdata <= 8'h00;
      end else if (!m_active) begin
         if (!mem_cs && !mute) begin
            m_active <= 1'b1; m_busy <= 1'b1; m_cnt <= 0; m_dr <= 1'b0;
         end
      end else if (m_cnt == 19) begin
         m_busy <= 1'b0; m_active <= 1'b0; m_dr <= 1'b1; m_rdata <= m_resp;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end
   assign mem_busy = m_busy | init_busy;

   always @(negedge clk) if (ack0 && ack1) both_seen = 1;

   task automatic run_port(input int p, input logic we, input logic [23:0] a, input logic [7:0] d,
                           output bit acked, output logic seen_we, output logic [23:0] seen_a,
                           output logic [7:0] seen_d, output int acks_p, output int acks_o);
      bit got_cs = 0;
      int post = 0;
      acked = 0; acks_p = 0; acks_o = 0; seen_we = 1'bx; seen_a = 'x; seen_d = 'x;
      if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1; end
      else        begin we1 = we; addr1 = a; wdata1 = d; req1 = 1; end
      for (int i = 0; i < 400 && post < 6; i++) begin
         @(negedge clk);
         if (acked) post++;
         if (!got_cs && !mem_cs) begin
            got_cs = 1; seen_we = mem_write; seen_a = mem_address; seen_d = mem_wdata;
         end
         if ((p == 0) ? ack0 : ack1) acks_p++;
         if ((p == 0) ? ack1 : ack0) acks_o++;
         if (!acked && ((p == 0) ? ack0 : ack1)) begin
            acked = 1;
            if (p == 0) req0 = 0; else req1 = 0;
         end
      end
   endtask

   task automatic test_reset();
      int lows = 0, runs = 0;
      logic prev = 1'b1;
      bit acked = 0;
      rst_n = 0; init_busy = 1;
      we1 = 1; addr1 = 24'h000010; wdata1 = 8'h11; req1 = 1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({mem_cs, ack0, ack1, mem_write, timeout, rdata0, rdata1, mem_address, mem_wdata} !==
          {1'b1, 4'b0, 8'h00, 8'h00, 24'h0, 8'h00})
         $display("FAIL reset_state: cs=%b ack=%b%b we=%b to=%b rd0=%h rd1=%h addr=%h wd=%h, required cs=1 others 0",
                  mem_cs, ack0, ack1, mem_write, timeout, rdata0, rdata1, mem_address, mem_wdata);
      if ({mem_cs, ack0, ack1, mem_write, timeout, rdata0, rdata1, mem_address, mem_wdata} !==
          {1'b1, 4'b0, 8'h00, 8'h00, 24'h0, 8'h00}) errors++;
      rst_n = 1;
      repeat (100) begin @(negedge clk); if (!mem_cs) lows++; end
      vectors++;
      if (lows !== 0) begin errors++; $display("FAIL init_busy_cs: %0d cs-low cycles, required 0", lows); end
      init_busy = 0;
      for (int i = 0; i < 200 && !acked; i++) begin
         @(negedge clk);
         if (prev && !mem_cs) runs++;
         prev = mem_cs;
         if (ack1) begin acked = 1; req1 = 0; end
      end
      repeat (10) begin @(negedge clk); if (prev && !mem_cs) runs++; prev = mem_cs; end
      vectors++;
      if (!acked) begin errors++; $display("FAIL init_ack1: no ack1, required one"); end
      vectors++;
      if (runs !== 1) begin errors++; $display("FAIL init_cs_runs: %0d, required 1", runs); end
   endtask

   task automatic test_read_port0();
      bit acked; logic swe; logic [23:0] sa; logic [7:0] sd; int ap, ao;
      m_resp = 8'h3C;
      run_port(0, 1'b0, 24'h00D000, 8'h00, acked, swe, sa, sd, ap, ao);
      vectors++; if (!acked) begin errors++; $display("FAIL rd_ack0: none, required 1"); end
      vectors++; if (swe !== 1'b0) begin errors++; $display("FAIL rd_we: %b, required 0", swe); end
      vectors++; if (sa !== 24'h00D000) begin errors++; $display("FAIL rd_addr: %h, required 00d000", sa); end
      vectors++; if (rdata0 !== 8'h3C) begin errors++; $display("FAIL rd_rdata0: %h, required 3c", rdata0); end
      vectors++; if (rdata1 !== 8'h00) begin errors++; $display("FAIL rd_rdata1: %h, required 00", rdata1); end
   endtask

   task automatic test_write_port1();
      bit acked; logic swe; logic [23:0] sa; logic [7:0] sd; int ap, ao;
      run_port(1, 1'b1, 24'h000400, 8'hA5, acked, swe, sa, sd, ap, ao);
      vectors++; if (swe !== 1'b1) begin errors++; $display("FAIL wr_we: %b, required 1", swe); end
      vectors++; if (sa !== 24'h000400) begin errors++; $display("FAIL wr_addr: %h, required 000400", sa); end
      vectors++; if (sd !== 8'hA5) begin errors++; $display("FAIL wr_data: %h, required a5", sd); end
      vectors++; if (ap !== 1) begin errors++; $display("FAIL wr_ack1_count: %0d, required 1", ap); end
      vectors++; if (ao !== 0) begin errors++; $display("FAIL wr_ack0_count: %0d, required 0", ao); end
      vectors++; if (rdata0 !== 8'h3C) begin errors++; $display("FAIL wr_rdata0_hold: %h, required 3c", rdata0); end
   endtask

   task automatic test_back_to_back();
      int order[4];
      int exp[4];
      int n = 0;
`ifdef ARB_ROUND_ROBIN_EN
      exp = '{0, 1, 0, 1};
`else
      exp = '{0, 0, 0, 0};
`endif
      m_resp = 8'h55;
      we0 = 0; addr0 = 24'h000100; we1 = 0; addr1 = 24'h000200;
      req0 = 1; req1 = 1;
      for (int i = 0; i < 2000 && n < 4; i++) begin
         @(negedge clk);
         if (ack0) begin order[n] = 0; n++; end
         else if (ack1) begin order[n] = 1; n++; end
         if (n == 4) begin req0 = 0; req1 = 0; end
      end
      req0 = 0; req1 = 0;
      repeat (5) @(negedge clk);
      vectors++; if (n !== 4) begin errors++; $display("FAIL b2b_count: %0d acks, required 4", n); end
      for (int k = 0; k < n; k++) begin
         vectors++;
         if (order[k] !== exp[k]) begin
            errors++; $display("FAIL b2b_order[%0d]: port %0d, required %0d", k, order[k], exp[k]);
         end
      end
   endtask

   task automatic test_timeout();
      bit acked; logic swe; logic [23:0] sa; logic [7:0] sd; int ap, ao;
      mute = 1;
      run_port(0, 1'b0, 24'h000123, 8'h00, acked, swe, sa, sd, ap, ao);
      vectors++; if (!acked) begin errors++; $display("FAIL to_ack0: none, required 1"); end
      vectors++; if (mem_cs !== 1'b1) begin errors++; $display("FAIL to_cs: %b, required 1", mem_cs); end
      vectors++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag: %b, required 1", timeout); end
      vectors++; if (rdata0 !== 8'h55) begin errors++; $display("FAIL to_rdata0: %h, required 55", rdata0); end
      mute = 0; m_resp = 8'h77;
      run_port(1, 1'b0, 24'h000200, 8'h00, acked, swe, sa, sd, ap, ao);
      vectors++; if (!acked) begin errors++; $display("FAIL to_next_ack1: none, required 1"); end
      vectors++; if (rdata1 !== 8'h77) begin errors++; $display("FAIL to_next_rdata1: %h, required 77", rdata1); end
      vectors++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: %b, required 1", timeout); end
   endtask

   task automatic test_reset_in_wait();
      int acks = 0;
      bit busy_seen = 0;
      m_resp = 8'h99;
      we0 = 0; addr0 = 24'h000050; req0 = 1;
      for (int i = 0; i < 50 && !busy_seen; i++) begin @(negedge clk); if (m_busy) busy_seen = 1; end
      repeat (3) @(negedge clk);
      vectors++; if (!busy_seen) begin errors++; $display("FAIL rw_busy: never busy, required busy"); end
      rst_n = 0;
      #1;
      vectors++;
      if ({mem_cs, ack0, ack1, mem_write, timeout, rdata0, rdata1, mem_address, mem_wdata} !==
          {1'b1, 4'b0, 8'h00, 8'h00, 24'h0, 8'h00}) begin
         errors++;
         $display("FAIL rw_reset_vals: cs=%b ack=%b%b we=%b to=%b rd0=%h rd1=%h addr=%h wd=%h, required cs=1 others 0",
                  mem_cs, ack0, ack1, mem_write, timeout, rdata0, rdata1, mem_address, mem_wdata);
      end
      req0 = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (40) begin @(negedge clk); if (ack0 || ack1) acks++; end
      vectors++; if (acks !== 0) begin errors++; $display("FAIL rw_no_ack: %0d acks, required 0", acks); end
      vectors++; if (both_seen) begin errors++; $display("FAIL ack_overlap: seen, required never"); end
   endtask

   initial begin
      rst_n = 0; init_busy = 0; mute = 0; m_resp = 8'h00;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      test_reset();
      test_read_port0();
      test_write_port1();
      test_back_to_back();
      test_timeout();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
